gray_rx_monitor: RTL and testbench

//  Receive side of the N-bit Gray counter output: samples a Gray-coded bus, decodes it
//  to binary, classifies each sample as hold/up/down/illegal step, and tracks lock.

---
 rtl/gray_pkg.sv | 38 +++
 rtl/gray2bin_comb.sv | 20 ++
 rtl/gray_rx_monitor.sv | 163 ++++++++++++++++
 tb/tb_gray_rx_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared FSM encodings and Gray decode helper for the Gray receive path
//
// Purpose: state encodings for the Gray receive monitor FSM and a width-generic
//          Gray-to-binary helper shared with Gray-source benches.
// Contents:
//   ST_IDLE / ST_ACQ / ST_LOCKED  2-bit state encodings
//   state_t                       FSM state enum built on those encodings
//   gray2bin(g, n)                decodes the low n bits of g (n <= GMAX)
package gray_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACQ    = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam int GMAX = 32;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ACQ    = ST_ACQ,
      LOCKED = ST_LOCKED
   } state_t;

   // Binary bit i is the XOR of all Gray bits from the top down to bit i.
   function automatic logic [GMAX-1:0] gray2bin(input logic [GMAX-1:0] g, input int n);
      logic [GMAX-1:0] msk;
      logic [GMAX-1:0] b;
      msk = '0;
      b   = '0;
      for (int j = 0; j < GMAX; j++) begin
         if (j < n) msk[j] = 1'b1;
      end
      for (int i = 0; i < GMAX; i++) begin
         if (i < n) b[i] = ^((g & msk) >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// rtl/gray2bin_comb.sv - combinational N-bit Gray-to-binary decoder
//
// Purpose: pure combinational decode, b[N-1] = g[N-1], b[i] = b[i+1] ^ g[i].
// Ports:
//   gray  in  N  Gray-coded value
//   bin   out N  binary value
module gray2bin_comb #(
   parameter int N = 4
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   // Unrolled prefix XOR: each bit reduces the Gray bits at and above it,
   // which avoids a bit-to-bit dependency chain inside one vector.
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign bin[i] = ^gray[N-1:i];
   end

endmodule

// File: rtl/gray_rx_monitor.sv
// rtl/gray_rx_monitor.sv - Gray bus receiver: decode, step classification, lock and error stats
//
// Purpose: samples a Gray-coded bus, decodes it to binary two edges later, flags each
//          sample as hold/up/down/illegal relative to the previous one, and tracks lock.
// Ports:
//   clk        in   1    system clock, rising edge
//   rst        in   1    synchronous active-high reset
//   clk_en     in   1    sample enable for gray_in
//   gray_in    in   N    Gray-coded input bus
//   clr_err    in   1    synchronous clear of err_count
//   bin_out    out  N    decoded value of last accepted sample
//   valid      out  1    pulse: bin_out and step flags updated
//   step_up    out  1    pulse: +1 step
//   step_down  out  1    pulse: -1 step
//   err        out  1    pulse: illegal step
//   locked     out  1    level: FSM in LOCKED
//   err_count  out  ECW  saturating illegal-step count
module gray_rx_monitor
   import gray_pkg::*;
#(
   parameter int N        = 4,
   parameter int LOCK_CNT = 3,
   parameter int ECW      = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clk_en,
   input  logic [N-1:0]   gray_in,
   input  logic           clr_err,
   output logic [N-1:0]   bin_out,
   output logic           valid,
   output logic           step_up,
   output logic           step_down,
   output logic           err,
   output logic           locked,
   output logic [ECW-1:0] err_count
);

   localparam int LCW = $clog2(LOCK_CNT + 1);

   logic [N-1:0]   gray_q;
   logic           s1_v;
   logic [N-1:0]   bin_s2;
   logic [N-1:0]   prev_bin;
   logic [N-1:0]   diff;
   state_t         state;
   state_t         state_nx;
   logic [LCW-1:0] lock_cnt;
   logic [LCW-1:0] lock_cnt_nx;
   logic           is_up;
   logic           is_down;
   logic           is_err;

   // Stage 1: capture. A pending sample is dropped by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         gray_q <= '0;
         s1_v   <= 1'b0;
      end else begin
         s1_v <= clk_en;
         if (clk_en) gray_q <= gray_in;
      end
   end

   gray2bin_comb #(.N(N)) u_dec (
      .gray (gray_q),
      .bin  (bin_s2)
   );

   // Modular difference makes wrap-around (max->0, 0->max) a legal single step.
   assign diff = bin_s2 - prev_bin;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lock_cnt <= '0;
      end else begin
         state    <= state_nx;
         lock_cnt <= lock_cnt_nx;
      end
   end

   // Classifier and next-state logic; only a stage-2 sample moves anything.
   always_comb begin
      is_up       = 1'b0;
      is_down     = 1'b0;
      is_err      = 1'b0;
      state_nx    = state;
      lock_cnt_nx = lock_cnt;
      if (s1_v) begin
         if (state == IDLE) begin
            // First sample only seeds prev_bin; there is nothing to compare against.
            state_nx    = ACQ;
            lock_cnt_nx = '0;
         end else begin
            if (diff == N'(1))       is_up   = 1'b1;
            else if (diff == '1)     is_down = 1'b1;
            else if (diff != '0)     is_err  = 1'b1;
            case (state)
               ACQ: begin
                  if (is_err) begin
                     lock_cnt_nx = '0;
                  end else if (is_up || is_down) begin
                     if (lock_cnt == LCW'(LOCK_CNT - 1)) begin
                        state_nx    = LOCKED;
                        lock_cnt_nx = '0;
                     end else begin
                        lock_cnt_nx = lock_cnt + 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  if (is_err) begin
                     state_nx    = ACQ;
                     lock_cnt_nx = '0;
                  end
               end
               default: begin
                  state_nx    = IDLE;
                  lock_cnt_nx = '0;
               end
            endcase
         end
      end
   end

   assign locked = (state == LOCKED);

   // Stage 2 outputs. prev_bin follows every sample, illegal ones included,
   // so a single glitch costs one err rather than a stream of them.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_out   <= '0;
         prev_bin  <= '0;
         valid     <= 1'b0;
         step_up   <= 1'b0;
         step_down <= 1'b0;
         err       <= 1'b0;
      end else begin
         valid     <= s1_v;
         step_up   <= is_up;
         step_down <= is_down;
         err       <= is_err;
         if (s1_v) begin
            bin_out  <= bin_s2;
            prev_bin <= bin_s2;
         end
      end
   end

   // Clear beats a coincident error.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= '0;
      end else if (is_err && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_gray_rx_monitor.sv
// tb/tb_gray_rx_monitor.sv - self-checking bench for gray_rx_monitor (ECW=8 and ECW=2 instances)
module tb_gray_rx_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b0;
   logic [3:0] gray_in = 4'd0;
   logic       clr_err = 1'b0;

   logic [3:0] b8, b2;
   logic       v8, u8, d8, e8, l8;
   logic       v2, u2, d2, e2, l2;
   logic [7:0] ec8_dut;
   logic [1:0] ec2_dut;

   int vectors = 0;
   int miscompares = 0;
   bit chk_on = 1'b0;

   int up_seen, dn_seen, err_seen;

   always #5 clk = ~clk;

   gray_rx_monitor #(.N(4), .LOCK_CNT(3), .ECW(8)) dut8 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .gray_in(gray_in), .clr_err(clr_err),
      .bin_out(b8), .valid(v8), .step_up(u8), .step_down(d8), .err(e8),
      .locked(l8), .err_count(ec8_dut)
   );

   gray_rx_monitor #(.N(4), .LOCK_CNT(3), .ECW(2)) dut2 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .gray_in(gray_in), .clr_err(clr_err),
      .bin_out(b2), .valid(v2), .step_up(u2), .step_down(d2), .err(e2),
      .locked(l2), .err_count(ec2_dut)
   );

   // ---------------- behavioural model ----------------
   int  e_bin, e_valid, e_up, e_dn, e_err, e_lock, e_ec8, e_ec2;
   int  p_v, p_g, m_prev, m_first, m_steps;

   function automatic int g2b(input int g);
      int b, t;
      b = g;
      t = g >> 1;
      while (t != 0) begin
         b = b ^ t;
         t = t >> 1;
      end
      return b;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         e_bin = 0; e_valid = 0; e_up = 0; e_dn = 0; e_err = 0; e_lock = 0;
         e_ec8 = 0; e_ec2 = 0; p_v = 0; p_g = 0; m_prev = 0; m_first = 1; m_steps = 0;
      end else begin
         int b, d;
         e_valid = 0; e_up = 0; e_dn = 0; e_err = 0;
         if (p_v != 0) begin
            b = g2b(p_g);
            e_valid = 1;
            if (m_first != 0) begin
               m_first = 0;
               e_lock  = 0;
               m_steps = 0;
            end else begin
               d = (b - m_prev + 16) % 16;
               if (d == 1)       e_up  = 1;
               else if (d == 15) e_dn  = 1;
               else if (d != 0)  e_err = 1;
               if (e_err != 0) begin
                  e_lock  = 0;
                  m_steps = 0;
               end else if ((e_up != 0 || e_dn != 0) && e_lock == 0) begin
                  m_steps++;
                  if (m_steps == 3) begin
                     e_lock  = 1;
                     m_steps = 0;
                  end
               end
            end
            m_prev = b;
            e_bin  = b;
         end
         if (clr_err) begin
            e_ec8 = 0;
            e_ec2 = 0;
         end else if (e_err != 0) begin
            if (e_ec8 < 255) e_ec8++;
            if (e_ec2 < 3)   e_ec2++;
         end
         p_v = clk_en ? 1 : 0;
         if (clk_en) p_g = int'(gray_in);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         chk("valid8", int'(v8), e_valid);
         chk("bin8",   int'(b8), e_bin);
         chk("up8",    int'(u8), e_up);
         chk("down8",  int'(d8), e_dn);
         chk("err8",   int'(e8), e_err);
         chk("lock8",  int'(l8), e_lock);
         chk("ec8",    int'(ec8_dut), e_ec8);
         chk("valid2", int'(v2), e_valid);
         chk("bin2",   int'(b2), e_bin);
         chk("up2",    int'(u2), e_up);
         chk("down2",  int'(d2), e_dn);
         chk("err2",   int'(e2), e_err);
         chk("lock2",  int'(l2), e_lock);
         chk("ec2",    int'(ec2_dut), e_ec2);
         up_seen  += int'(u8);
         dn_seen  += int'(d8);
         err_seen += int'(e8);
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_rst();
      rst = 1'b1;
      clk_en = 1'b0;
      clr_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      up_seen = 0; dn_seen = 0; err_seen = 0;
   endtask

   task automatic put(input logic [3:0] g);
      gray_in = g;
      clk_en  = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      clk_en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      up_seen = 0; dn_seen = 0; err_seen = 0;
      @(negedge clk);
      @(negedge clk);
      do_rst();
      chk_on = 1'b1;
      // reset state
      chk("rst_valid", int'(v8), 0);
      chk("rst_bin",   int'(b8), 0);
      chk("rst_lock",  int'(l8), 0);
      chk("rst_ec",    int'(ec8_dut), 0);

      // 1: count 0..4
      put(4'b0000); put(4'b0001); put(4'b0011); put(4'b0010); put(4'b0110);
      idle(3);
      chk("t1_bin",  int'(b8), 4);
      chk("t1_lock", int'(l8), 1);
      chk("t1_ups",  up_seen, 4);
      chk("t1_ec",   int'(ec8_dut), 0);

      // 2: wrap 14,15,0
      do_rst();
      put(4'b1001); put(4'b1000); put(4'b0000);
      idle(3);
      chk("t2_bin",  int'(b8), 0);
      chk("t2_ups",  up_seen, 2);
      chk("t2_errs", err_seen, 0);
      chk("t2_lock", int'(l8), 0);

      // 3: reverse 3,2,1,0
      do_rst();
      put(4'b0010); put(4'b0011); put(4'b0001); put(4'b0000);
      idle(3);
      chk("t3_dns",  dn_seen, 3);
      chk("t3_lock", int'(l8), 1);

      // 4: lock at 15,0,1,2 then jump 2->6, relock with 5,4,3
      do_rst();
      put(4'b1000); put(4'b0000); put(4'b0001); put(4'b0011);
      idle(3);
      chk("t4_lock_a", int'(l8), 1);
      put(4'b0101);
      idle(3);
      chk("t4_bin",   int'(b8), 6);
      chk("t4_errs",  err_seen, 1);
      chk("t4_lock_b", int'(l8), 0);
      chk("t4_ec",    int'(ec8_dut), 1);
      put(4'b0111); put(4'b0110); put(4'b0010);
      idle(3);
      chk("t4_lock_c", int'(l8), 1);
      chk("t4_bin_c",  int'(b8), 3);

      // 5: clk_en toggling with hold samples
      do_rst();
      put(4'b0000); idle(1);
      put(4'b0000); idle(1);
      put(4'b0001); idle(1);
      put(4'b0001); idle(1);
      put(4'b0011); idle(3);
      chk("t5_ups",  up_seen, 2);
      chk("t5_bin",  int'(b8), 2);
      chk("t5_lock", int'(l8), 0);

      // 6: saturation, clear vs err, reset mid-stream
      do_rst();
      put(4'b0000); put(4'b1100); put(4'b0000); put(4'b1100); put(4'b0000); put(4'b1100);
      idle(3);
      chk("t6_ec8", int'(ec8_dut), 5);
      chk("t6_ec2", int'(ec2_dut), 3);
      put(4'b0000);
      clk_en  = 1'b0;
      clr_err = 1'b1;      // lands on the edge that produces the err pulse
      @(negedge clk);
      clr_err = 1'b0;
      idle(2);
      chk("t6_errs", err_seen, 6);
      chk("t6_clr8", int'(ec8_dut), 0);
      chk("t6_clr2", int'(ec2_dut), 0);
      put(4'b0001);
      rst = 1'b1;
      clk_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_bin", int'(b8), 0);
      chk("t6_rst_v",   int'(v8), 0);
      err_seen = 0;
      put(4'b1100);
      idle(3);
      chk("t6_first_bin",  int'(b8), 8);
      chk("t6_first_errs", err_seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
